// File: rtl/alu_result_fifo.sv
// Result buffer between the 32-bit ALU and write-back: DEPTH-entry circular FIFO
// carrying result, carry-out and destination tag, with a locally regenerated zero flag.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_cout,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_zero,
    output logic                     out_cout,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]      result;
        logic             cout;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_drop_err;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    // Full/empty come from the occupancy count, so pointer equality is never ambiguous.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && out_ready && !flush;

    // NOTE: the storage array has no reset; occupancy decides what is valid, and
    // leaving it out of the reset net keeps it a plain register file/RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{result: in_result, cout: in_cout, tag: in_tag};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (in_valid && w_full) begin
                r_drop_err <= 1'b1;
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: default assignment first so the empty case cannot infer a latch.
    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_result = w_head.result;
    assign out_cout   = w_head.cout;
    assign out_tag    = w_head.tag;
    assign out_zero   = (w_head.result == 32'd0) && !w_empty;
    assign count      = r_count;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_result;
    logic               in_cout;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic               out_zero;
    logic               out_cout;
    logic [TAG_W-1:0]   out_tag;
    logic [CNT_W-1:0]   count;
    logic               drop_err;

    alu_result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_cout   (out_cout),
        .out_tag    (out_tag),
        .count      (count),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic             c;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    logic m_drop;
    int   n_vec;
    int   n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        ent_t h;
        h = '{res: '0, c: 1'b0, tag: '0};
        if (q.size() > 0) h = q[0];
        check({tag, ".in_ready"},   32'(in_ready),   32'(q.size() != DEPTH));
        check({tag, ".out_valid"},  32'(out_valid),  32'(q.size() != 0));
        check({tag, ".count"},      32'(count),      32'(q.size()));
        check({tag, ".out_result"}, out_result,      h.res);
        check({tag, ".out_zero"},   32'(out_zero),   32'((q.size() != 0) && (h.res == 0)));
        check({tag, ".out_cout"},   32'(out_cout),   32'(h.c));
        check({tag, ".out_tag"},    32'(out_tag),    32'(h.tag));
        check({tag, ".drop_err"},   32'(drop_err),   32'(m_drop));
    endtask

    // Applies one cycle of stimulus, advances the model over the edge, then compares.
    task automatic step(input string tag, input logic v, input logic [31:0] res,
                        input logic c, input logic [TAG_W-1:0] t,
                        input logic ordy, input logic fl);
        bit full;
        bit do_pop;
        in_valid  = v;
        in_result = res;
        in_cout   = c;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        full = (q.size() == DEPTH);
        if (v && full) m_drop = 1'b1;
        if (fl) begin
            q.delete();
        end else begin
            do_pop = (q.size() > 0) && ordy;
            if (do_pop) void'(q.pop_front());
            if (v && !full) q.push_back('{res: res, c: c, tag: t});
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, 32'h0, 1'b0, '0, ordy, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_drop    = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_cout   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #6 rst_n = 1'b1;

        // 1: single push then pop
        step("t1_push", 1'b1, 32'h5, 1'b1, 5'd3, 1'b0, 1'b0);
        check("t1_result_lit", out_result, 32'h5);
        idle("t1_pop", 1'b1);

        // 2: zero detect
        step("t2_push0", 1'b1, 32'h0, 1'b0, 5'd7, 1'b0, 1'b0);
        check("t2_zero_lit", 32'(out_zero), 32'd1);
        idle("t2_pop", 1'b1);

        // 3: fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) step("t3_fill", 1'b1, 32'(i * 16), 1'b0, 5'(i), 1'b0, 1'b0);
        check("t3_full_lit", 32'(in_ready), 32'd0);
        step("t3_ovf", 1'b1, 32'h50, 1'b1, 5'd9, 1'b0, 1'b0);
        check("t3_drop_lit", 32'(drop_err), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", out_result, 32'(i * 16));
            idle("t3_drain", 1'b1);
        end

        // 4: streaming with concurrent pop, pointers wrap
        step("t4_first", 1'b1, 32'd1, 1'b0, 5'd1, 1'b0, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            check("t4_order", out_result, 32'(i - 1));
            step("t4_stream", 1'b1, 32'(i), 1'b1, 5'(i), 1'b1, 1'b0);
            check("t4_cnt_le1", 32'(count <= 1), 32'd1);
        end
        check("t4_last", out_result, 32'd6);
        idle("t4_drain", 1'b1);

        // 5: full with simultaneous push attempt and pop
        for (int i = 0; i < 4; i++) step("t5_fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 5'(i), 1'b0, 1'b0);
        step("t5_fullpop", 1'b1, 32'h99, 1'b0, 5'd31, 1'b1, 1'b0);
        check("t5_count_lit", 32'(count), 32'd3);

        // 6: flush with 3 entries, then async reset mid-cycle
        step("t6_flush", 1'b1, 32'h77, 1'b0, 5'd2, 1'b1, 1'b1);
        check("t6_drop_kept", 32'(drop_err), 32'd1);
        step("t6_refill", 1'b1, 32'h11, 1'b0, 5'd4, 1'b0, 1'b0);
        step("t6_refill", 1'b1, 32'h12, 1'b1, 5'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_drop = 1'b0;
        check_all("t6_async_rst");
        #2 rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step("rand", 1'($urandom_range(0, 99) < 60), r, 1'($urandom),
                 TAG_W'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream buffer stage for the 32-bit ALU: captures each ALU result with its carry-out and destination tag, then hands it to the write-back stage over a valid/ready handshake.
- Decouples ALU issue from write-back stalls; DEPTH entries in a circular buffer.
- Regenerates the zero flag locally from the stored result.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- TAG_W, 5, width of destination-register tag carried with each result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries; has priority over push/pop.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  FIFO can accept; equals !full.
- in_result  in  32  ALU result word.
- in_cout  in  1  ALU carry-out.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  head entry available; equals !empty.
- out_ready  in  1  write-back consumes head.
- out_result  out  32  head result.
- out_zero  out  1  1 when out_result == 0; 0 when empty.
- out_cout  out  1  head carry-out.
- out_tag  out  TAG_W  head tag.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_err  out  1  sticky: set when in_valid=1 while in_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, drop_err=0. Outputs: out_valid=0, in_ready=1, out_result=0, out_zero=0, out_cout=0, out_tag=0. Storage contents need not be cleared.
- Push: the entry is written at a rising edge when in_valid && in_ready && !flush. wr_ptr advances mod DEPTH.
- Pop: the head is consumed at a rising edge when out_valid && out_ready && !flush. rd_ptr advances mod DEPTH.
- Latency: data pushed at edge N appears on the outputs with out_valid=1 after edge N. There is no combinational in->out bypass.
- Output data:
  - out_result, out_cout and out_tag come from the entry at rd_ptr.
  - When empty, all outputs are forced to 0.
  - out_zero is computed as (out_result == 0) && out_valid.
- Full: count == DEPTH gives in_ready=0.
  - A push attempt while full is dropped and sets drop_err.
  - A simultaneous pop while full still occurs, so count drops to DEPTH-1.
  - No push is accepted that cycle; in_ready depends only on registered state.
- Empty: count == 0 gives out_valid=0. out_ready is ignored.
- Simultaneous push and pop (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- Pointer wrap: the pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are determined from count, not pointer compare.
- Flush:
  - Next edge sets wr_ptr=rd_ptr=0 and count=0.
  - The in-flight push and pop that cycle are discarded.
  - drop_err is not cleared by flush, only by reset.
- drop_err: once set, it stays 1 until rst_n is asserted.
- Reset mid-operation: all entries are lost immediately (asynchronous) and the outputs return to their reset values before the next edge.
- Tag and carry are stored bit-exact. No arithmetic is performed on stored data apart from the zero detect.

Test Plan:
1. Reset then a single push of result=0x0000_0005, cout=1, tag=3. After one edge: out_valid=1, out_result=5, out_zero=0, out_cout=1, out_tag=3, count=1. Pop with out_ready=1: count=0, out_valid=0.
2. Zero detect: push result=0x0000_0000, tag=7 -> out_zero=1, out_valid=1. Pop -> out_zero=0.
3. Fill and overflow (DEPTH=4): push 0x10, 0x20, 0x30, 0x40 -> count=4, in_ready=0. Push 0x50 -> dropped, drop_err=1. Pops return 0x10, 0x20, 0x30, 0x40 in order.
4. Wrap plus concurrent traffic:
   - Push 6 values 1..6 with out_ready=1 continuously from cycle 2.
   - Required: outputs appear in order 1..6, count never exceeds 1, and the pointers wrap past 3 with no loss.
5. Full plus simultaneous pop: at count=4 assert in_valid (0x99) and out_ready. Required: head popped, 0x99 not stored, drop_err=1, count=3.
6. Flush and async reset:
   - With 3 entries, flush=1 for one edge -> count=0, out_valid=0, drop_err unchanged.
   - Refill 2 entries, then drop rst_n mid-cycle -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
